// File: rtl/hpm_counters.sv
// Hardware performance-monitor CSRs: mhpmcounter/mhpmevent 3..31, mcountinhibit,
// mcounteren and the user hpmcounter shadows, with a registered overflow interrupt.
module hpm_counters #(
    parameter int NUM_COUNTERS = 4,
    parameter int CNT_WIDTH    = 48,
    parameter int NUM_EVENTS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_pulses,
    input  logic [1:0]            privilege_mode,
    input  logic                  csr_valid,
    input  logic [11:0]           csr_addr,
    input  logic [2:0]            csr_funct3,
    input  logic [4:0]            csr_rd,
    input  logic [4:0]            csr_rs1_uimm,
    input  logic [63:0]           csr_rs1_data,
    output logic                  csr_hit,
    output logic                  csr_exception,
    output logic [63:0]           csr_result,
    output logic                  inhibit_cy,
    output logic                  inhibit_ir,
    output logic                  ovf_int
);

    localparam logic [31:0] CTR_MASK = 32'h5 | (((32'd1 << NUM_COUNTERS) - 32'd1) << 3);

    logic [CNT_WIDTH-1:0]    cnt_q [NUM_COUNTERS];
    logic [7:0]              sel_q [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] of_q;
    logic [31:0]             inhibit_q;
    logic [31:0]             counteren_q;

    logic [4:0]   idx;
    logic         idx_hpm;
    logic         in_mcnt, in_mevt, in_ucnt, is_inh, is_en;
    logic         do_write, rd_en, we;
    logic [63:0]  rdata, src, wdata;
    logic [255:0] ev_ext;
    logic [NUM_COUNTERS-1:0] wr_cnt, wr_evt, inc, wrap;

    assign idx     = csr_addr[4:0];
    assign idx_hpm = (idx >= 5'd3);
    assign in_mcnt = (csr_addr[11:5] == 7'h58) && idx_hpm;
    assign in_mevt = (csr_addr[11:5] == 7'h19) && idx_hpm;
    assign in_ucnt = (csr_addr[11:5] == 7'h60) && idx_hpm;
    assign is_inh  = (csr_addr == 12'h320);
    assign is_en   = (csr_addr == 12'h306);
    assign csr_hit = is_inh | is_en | in_mcnt | in_mevt | in_ucnt;

    // Unimplemented indices never match the loop, so they read 0 and ignore writes.
    always_comb begin
        rdata = '0;
        if (is_inh) begin
            rdata = 64'(inhibit_q);
        end else if (is_en) begin
            rdata = 64'(counteren_q);
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (idx == 5'(i + 3)) begin
                if (in_mcnt || in_ucnt) begin
                    rdata = 64'(cnt_q[i]);
                end else if (in_mevt) begin
                    rdata = {of_q[i], 55'd0, sel_q[i]};
                end
            end
        end
    end

    assign do_write = (csr_funct3[1:0] == 2'b01) ||
                      ((csr_funct3[1:0] != 2'b00) && (csr_rs1_uimm != 5'd0));
    assign rd_en    = !((csr_funct3[1:0] == 2'b01) && (csr_rd == 5'd0));
    assign src      = csr_funct3[2] ? {59'd0, csr_rs1_uimm} : csr_rs1_data;

    always_comb begin
        case (csr_funct3[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = rdata | src;
            2'b11:   wdata = rdata & ~src;
            default: wdata = rdata;
        endcase
    end

    assign csr_exception = csr_hit &&
                           ((do_write && in_ucnt) ||
                            (csr_addr[9:8] > privilege_mode) ||
                            ((privilege_mode == 2'd0) && in_ucnt && !counteren_q[idx]));
    assign we         = csr_valid && csr_hit && do_write && !csr_exception;
    assign csr_result = rd_en ? rdata : '0;
    assign inhibit_cy = inhibit_q[0];
    assign inhibit_ir = inhibit_q[2];

    // Bit 0 is a permanent zero so selector 0 indexes a quiet line; selectors above
    // NUM_EVENTS land in the zero padding.
    assign ev_ext = 256'({event_pulses, 1'b0});

    always_comb begin
        wr_cnt = '0;
        wr_evt = '0;
        inc    = '0;
        wrap   = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            wr_cnt[i] = we && in_mcnt && (idx == 5'(i + 3));
            wr_evt[i] = we && in_mevt && (idx == 5'(i + 3));
            inc[i]    = ev_ext[sel_q[i]] && !inhibit_q[i + 3];
            wrap[i]   = inc[i] && (&cnt_q[i]) && !wr_cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            of_q        <= '0;
            inhibit_q   <= '0;
            counteren_q <= '0;
            ovf_int     <= 1'b0;
        end else begin
            ovf_int <= |of_q;
            if (we && is_inh) begin
                inhibit_q <= wdata[31:0] & CTR_MASK;
            end
            if (we && is_en) begin
                counteren_q <= wdata[31:0] & CTR_MASK;
            end
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (wr_cnt[i]) begin
                    cnt_q[i] <= wdata[CNT_WIDTH-1:0];
                end else if (inc[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
                // A hardware overflow in the same cycle beats a software clear of OF.
                if (wr_evt[i]) begin
                    sel_q[i] <= wdata[7:0];
                    of_q[i]  <= wdata[63] | wrap[i];
                end else if (wrap[i]) begin
                    of_q[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hpm_counters.sv
// Directed bench for hpm_counters: a per-cycle reference model of the CSR rules plus
// literal spot checks at each test-plan step.
module tb_hpm_counters;

    localparam int NC = 4;
    localparam int CW = 48;
    localparam int NE = 8;
    localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NE-1:0] event_pulses = '0;
    logic [1:0]    privilege_mode = 2'd3;
    logic          csr_valid = 1'b0;
    logic [11:0]   csr_addr = '0;
    logic [2:0]    csr_funct3 = '0;
    logic [4:0]    csr_rd = 5'd1;
    logic [4:0]    csr_rs1_uimm = '0;
    logic [63:0]   csr_rs1_data = '0;
    logic          csr_hit, csr_exception, inhibit_cy, inhibit_ir, ovf_int;
    logic [63:0]   csr_result;

    logic [1:0] pm = 2'd3;
    int n_cmp = 0;
    int n_bad = 0;

    hpm_counters #(.NUM_COUNTERS(NC), .CNT_WIDTH(CW), .NUM_EVENTS(NE)) dut (
        .clk(clk), .rst(rst), .event_pulses(event_pulses), .privilege_mode(privilege_mode),
        .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_funct3(csr_funct3), .csr_rd(csr_rd),
        .csr_rs1_uimm(csr_rs1_uimm), .csr_rs1_data(csr_rs1_data), .csr_hit(csr_hit),
        .csr_exception(csr_exception), .csr_result(csr_result), .inhibit_cy(inhibit_cy),
        .inhibit_ir(inhibit_ir), .ovf_int(ovf_int)
    );

    always #5 clk = ~clk;

    // Reference state, indexed by architectural counter number 0..31.
    logic [63:0] m_cnt [32];
    logic [7:0]  m_sel [32];
    logic        m_of  [32];
    logic [31:0] m_inh, m_en;
    logic        m_ovf;

    function automatic logic m_impl(input int i);
        return (i >= 3) && (i < 3 + NC);
    endfunction

    function automatic logic m_hit(input logic [11:0] a);
        return (a == 12'h320) || (a == 12'h306) ||
               (a >= 12'hB03 && a <= 12'hB1F) || (a >= 12'h323 && a <= 12'h33F) ||
               (a >= 12'hC03 && a <= 12'hC1F);
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        int i;
        i = int'(a[4:0]);
        if (a == 12'h320) return {32'd0, m_inh};
        if (a == 12'h306) return {32'd0, m_en};
        if (!m_hit(a) || !m_impl(i)) return 64'd0;
        if (a[11:8] == 4'hB || a[11:8] == 4'hC) return m_cnt[i];
        return {m_of[i], 55'd0, m_sel[i]};
    endfunction

    function automatic logic m_writes(input logic [2:0] f3, input logic [4:0] u);
        if (f3 == 3'd1 || f3 == 3'd5) return 1'b1;
        return (f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && (u != 5'd0);
    endfunction

    function automatic logic m_exc(input logic [11:0] a, input logic [2:0] f3,
                                   input logic [4:0] u, input logic [1:0] p);
        logic user;
        if (!m_hit(a)) return 1'b0;
        user = (a >= 12'hC03 && a <= 12'hC1F);
        return (m_writes(f3, u) && user) || (int'(a[9:8]) > int'(p)) ||
               (p == 2'd0 && user && !m_en[a[4:0]]);
    endfunction

    function automatic logic [63:0] m_wdata(input logic [11:0] a, input logic [2:0] f3,
                                            input logic [4:0] u, input logic [63:0] d);
        logic [63:0] s, old;
        s   = (f3 >= 3'd5) ? 64'(u) : d;
        old = m_read(a);
        if (f3 == 3'd1 || f3 == 3'd5) return s;
        if (f3 == 3'd2 || f3 == 3'd6) return old | s;
        return old & ~s;
    endfunction

    function automatic logic [31:0] m_ctl_mask(input logic [63:0] wd);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b == 0 || b == 2 || m_impl(b)) r[b] = wd[b];
        end
        return r;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 32; k++) begin
            m_cnt[k] = '0;
            m_sel[k] = '0;
            m_of[k]  = 1'b0;
        end
        m_inh = '0;
        m_en  = '0;
        m_ovf = 1'b0;
    endtask

    task automatic m_step();
        logic nxt_ovf, wr, hw, cnt_now;
        logic [63:0] wd;
        int s;
        nxt_ovf = 1'b0;
        for (int k = 3; k < 3 + NC; k++) nxt_ovf = nxt_ovf | m_of[k];
        wr = csr_valid && m_hit(csr_addr) && m_writes(csr_funct3, csr_rs1_uimm) &&
             !m_exc(csr_addr, csr_funct3, csr_rs1_uimm, privilege_mode);
        wd = m_wdata(csr_addr, csr_funct3, csr_rs1_uimm, csr_rs1_data);
        for (int k = 3; k < 3 + NC; k++) begin
            hw = 1'b0;
            s = int'(m_sel[k]);
            cnt_now = 1'b0;
            if (s >= 1 && s <= NE) cnt_now = event_pulses[s-1] && !m_inh[k];
            if (wr && int'(csr_addr) == 'hB00 + k) begin
                m_cnt[k] = wd & CMASK;
            end else if (cnt_now) begin
                if (m_cnt[k] == CMASK) begin
                    m_cnt[k] = 64'd0;
                    hw = 1'b1;
                end else begin
                    m_cnt[k] = m_cnt[k] + 64'd1;
                end
            end
            if (wr && int'(csr_addr) == 'h320 + k) begin
                m_sel[k] = wd[7:0];
                m_of[k]  = hw | wd[63];
            end else if (hw) begin
                m_of[k] = 1'b1;
            end
        end
        if (wr && csr_addr == 12'h320) m_inh = m_ctl_mask(wd);
        if (wr && csr_addr == 12'h306) m_en = m_ctl_mask(wd);
        m_ovf = nxt_ovf;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("model hit", 64'(csr_hit), 64'(m_hit(csr_addr)));
            if (m_hit(csr_addr)) begin
                chk("model exc", 64'(csr_exception),
                    64'(m_exc(csr_addr, csr_funct3, csr_rs1_uimm, privilege_mode)));
                chk("model result", csr_result, m_read(csr_addr));
            end
            chk("model ovf_int", 64'(ovf_int), 64'(m_ovf));
            chk("model inhibit_cy", 64'(inhibit_cy), 64'(m_inh[0]));
            chk("model inhibit_ir", 64'(inhibit_ir), 64'(m_inh[2]));
        end
    end

    task automatic op(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] u,
                      input logic [63:0] d, input logic [NE-1:0] ev);
        @(negedge clk);
        csr_valid      = 1'b1;
        csr_addr       = a;
        csr_funct3     = f3;
        csr_rs1_uimm   = u;
        csr_rs1_data   = d;
        event_pulses   = ev;
        privilege_mode = pm;
        #3;
    endtask

    task automatic rd(input logic [11:0] a, input logic [NE-1:0] ev);
        op(a, 3'b010, 5'd0, 64'd0, ev);
    endtask

    task automatic idle(input int n, input logic [NE-1:0] ev);
        repeat (n) begin
            @(negedge clk);
            csr_valid      = 1'b0;
            csr_addr       = '0;
            csr_funct3     = '0;
            csr_rs1_uimm   = '0;
            csr_rs1_data   = '0;
            event_pulses   = ev;
            privilege_mode = pm;
            #3;
        end
    endtask

    localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, RSI = 3'b110, RCI = 3'b111;
    localparam logic [63:0] OFB = 64'h8000_0000_0000_0000;

    initial begin
        idle(2, '0);
        rst = 1'b0;
        chk("reset ovf_int", 64'(ovf_int), 64'd0);
        chk("reset inhibit_cy", 64'(inhibit_cy), 64'd0);
        rd(12'hB03, '0);
        chk("reset cnt3", csr_result, 64'd0);

        // five pulses of event 1 on counter 3
        op(12'h323, RW, 5'd1, 64'd1, '0);
        idle(5, 8'h01);
        rd(12'hB03, '0);
        chk("count5 cnt3", csr_result, 64'd5);
        rd(12'hB04, '0);
        chk("count5 cnt4", csr_result, 64'd0);

        // wrap counter 4 via event 2
        op(12'hB04, RW, 5'd1, 64'h0000_FFFF_FFFF_FFFF, '0);
        op(12'h324, RW, 5'd1, 64'd2, '0);
        idle(1, 8'h02);
        rd(12'hB04, '0);
        chk("wrap cnt4", csr_result, 64'd0);
        chk("wrap ovf_int lag", 64'(ovf_int), 64'd0);
        rd(12'h324, '0);
        chk("wrap evt4", csr_result, OFB | 64'd2);
        chk("wrap ovf_int", 64'(ovf_int), 64'd1);
        op(12'h324, RC, 5'd1, OFB, '0);
        idle(2, '0);
        chk("clear ovf_int", 64'(ovf_int), 64'd0);

        // inhibit freezes counter 3 while event 1 pulses every cycle
        op(12'h320, RSI, 5'd8, 64'd0, 8'h01);
        idle(3, 8'h01);
        rd(12'hB03, 8'h01);
        chk("inhibit frozen", csr_result, 64'd6);
        op(12'h320, RCI, 5'd8, 64'd0, 8'h01);
        rd(12'hB03, 8'h01);
        chk("inhibit release", csr_result, 64'd6);
        rd(12'hB03, 8'h01);
        chk("inhibit resume", csr_result, 64'd7);

        // write beats increment; hardware overflow beats OF clear
        op(12'hB03, RW, 5'd1, 64'd100, 8'h01);
        rd(12'hB03, '0);
        chk("write wins", csr_result, 64'd100);
        op(12'h324, RS, 5'd1, OFB, '0);
        op(12'hB04, RW, 5'd1, CMASK, '0);
        op(12'h324, RC, 5'd1, OFB, 8'h02);
        rd(12'h324, '0);
        chk("hw of wins", csr_result, OFB | 64'd2);
        rd(12'hB04, '0);
        chk("hw of cnt4", csr_result, 64'd0);
        op(12'h324, RW, 5'd1, 64'd2, '0);

        // privilege
        pm = 2'd0;
        rd(12'hC03, '0);
        chk("U C03 no en", 64'(csr_exception), 64'd1);
        pm = 2'd3;
        op(12'h306, RSI, 5'd8, 64'd0, '0);
        pm = 2'd0;
        rd(12'hC03, '0);
        chk("U C03 en exc", 64'(csr_exception), 64'd0);
        chk("U C03 value", csr_result, 64'd100);
        rd(12'hB03, '0);
        chk("U B03 exc", 64'(csr_exception), 64'd1);
        op(12'hB03, RW, 5'd1, 64'd7, '0);
        pm = 2'd3;
        rd(12'hB03, '0);
        chk("U write blocked", csr_result, 64'd100);
        op(12'hC03, RW, 5'd1, 64'd55, '0);
        chk("M C03 write exc", 64'(csr_exception), 64'd1);
        rd(12'hB03, '0);
        chk("C03 write blocked", csr_result, 64'd100);

        // unimplemented index, foreign address, control register masking
        rd(12'hB0A, '0);
        chk("B0A hit", 64'(csr_hit), 64'd1);
        chk("B0A zero", csr_result, 64'd0);
        op(12'hB0A, RW, 5'd1, 64'd9, '0);
        rd(12'hB0A, '0);
        chk("B0A ignored", csr_result, 64'd0);
        rd(12'h7C0, '0);
        chk("7C0 miss", 64'(csr_hit), 64'd0);
        op(12'h320, RW, 5'd1, '1, '0);
        rd(12'h320, '0);
        chk("inhibit mask", csr_result, 64'h7D);
        chk("inhibit_cy set", 64'(inhibit_cy), 64'd1);
        chk("inhibit_ir set", 64'(inhibit_ir), 64'd1);
        op(12'h320, RW, 5'd1, 64'd0, '0);

        // reset mid-count
        idle(2, 8'h01);
        rd(12'hB03, 8'h01);
        rst = 1'b1;
        #1;
        chk("async rst cnt3", csr_result, 64'd0);
        chk("async rst ovf", 64'(ovf_int), 64'd0);
        idle(2, 8'h01);
        rst = 1'b0;
        rd(12'h323, 8'h01);
        chk("post rst evt3", csr_result, 64'd0);
        op(12'h323, RW, 5'd1, 64'd1, 8'h01);
        idle(2, 8'h01);
        rd(12'hB03, '0);
        chk("post rst count", csr_result, 64'd2);

        idle(2, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
